// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
// Provides default widths, the clear-FSM state type and a packed-slice helper.
package rf_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;

   // Low bit of lane idx in a packed bus of w-bit lanes.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: a claim marks a register as awaiting a producer,
// a committed write resolves it. Claim beats a same-cycle write.
// Ports:
//   clk, rst               clock, async active-high reset
//   en                     update enable (register file is in RUN)
//   clr_a_en/clr_a_addr    ALU write (resolves pending)
//   clr_b_en/clr_b_addr    ID write (resolves pending)
//   claim_en/claim_addr    new producer claim
//   pending                registered pending vector
module rf_scoreboard #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr_a_en,
   input  logic [ADDR_W-1:0]      clr_a_addr,
   input  logic                   clr_b_en,
   input  logic [ADDR_W-1:0]      clr_b_addr,
   input  logic                   claim_en,
   input  logic [ADDR_W-1:0]      claim_addr,
   output logic [2**ADDR_W-1:0]   pending
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam bit          ZR    = (ZERO_REG != 0);

   logic [DEPTH-1:0] pending_q, pending_d;

   // Clears first, then the claim, so a claim overrides a same-cycle write.
   always_comb begin
      pending_d = pending_q;
      if (en) begin
         if (clr_a_en) pending_d[clr_a_addr] = 1'b0;
         if (clr_b_en) pending_d[clr_b_addr] = 1'b0;
         if (claim_en) pending_d[claim_addr] = 1'b1;
      end
      if (ZR) pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   assign pending = pending_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with two write ports (ALU, ID), NUM_RD async
// read ports, a post-reset sequential clear, optional write bypass, optional
// hardwired zero register and a pending scoreboard.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rd_addr/rd_data           packed read addresses / data, lane k at k*W
//   rd_pending                pending bit of each addressed register
//   wa_en/wa_addr/wa_data     ALU write port
//   wi_en/wi_addr/wi_data     ID write port (wins on address collision)
//   claim_en/claim_addr       mark a register as awaiting a producer
//   ready                     initial clear finished
//   wr_conflict               one-cycle pulse after a same-address double write
module reg_file_sb
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_pending,
   input  logic                       wa_en,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic                       wi_en,
   input  logic [ADDR_W-1:0]          wi_addr,
   input  logic [DATA_W-1:0]          wi_data,
   input  logic                       claim_en,
   input  logic [ADDR_W-1:0]          claim_addr,
   output logic                       ready,
   output logic                       wr_conflict
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam bit          ZR    = (ZERO_REG != 0);
   localparam bit          BP    = (BYPASS != 0);

   rf_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               wr_conflict_q, wr_conflict_d;
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DEPTH-1:0]   pending;

   logic run;
   logic same_addr;
   logic wi_commit;
   logic wa_commit;

   assign run = (state_q == RUN);

   // Clear sequencer: one register per cycle, then RUN until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = RUN;
               ready_d = 1'b1;
            end
         end
         RUN: ;
      endcase
   end

   // Write commit decode; ID takes the slot when both ports hit one address.
   always_comb begin
      same_addr     = (wa_addr == wi_addr);
      wi_commit     = run && wi_en && !(ZR && (wi_addr == '0));
      wa_commit     = run && wa_en && !(wi_en && same_addr) && !(ZR && (wa_addr == '0));
      wr_conflict_d = run && wa_en && wi_en && same_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= INIT;
         cnt_q         <= '0;
         ready_q       <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   // Storage has no reset so it can map onto a RAM; INIT zeroes it instead.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem_q[cnt_q] <= '0;
      end else begin
         if (wi_commit) mem_q[wi_addr] <= wi_data;
         if (wa_commit) mem_q[wa_addr] <= wa_data;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .en         (run),
      .clr_a_en   (wa_en),
      .clr_a_addr (wa_addr),
      .clr_b_en   (wi_en),
      .clr_b_addr (wi_addr),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .pending    (pending)
   );

   // Read lanes: zero register, then bypass (ID before ALU), then storage.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] val;

      assign a = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

      always_comb begin
         val = mem_q[a];
         if (!run)                                 val = '0;
         else if (ZR && (a == '0))                 val = '0;
         else if (BP && wi_en && (wi_addr == a))   val = wi_data;
         else if (BP && wa_en && (wa_addr == a))   val = wa_data;
      end

      assign rd_data[slice_lo(k, DATA_W) +: DATA_W] = val;
      assign rd_pending[k] = run & pending[a];
   end

   assign ready       = ready_q;
   assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: two instances (default build, and a
// zero-register / no-bypass build) share stimulus and are compared against
// an array-based reference model plus directed literal expectations.
module tb_reg_file_sb;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 3;
   localparam int unsigned NR    = 2;
   localparam int unsigned DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NR*AW-1:0]    rd_addr;
   logic [NR*DW-1:0]    rd_data_a, rd_data_b;
   logic [NR-1:0]       rd_pend_a, rd_pend_b;
   logic                wa_en, wi_en, claim_en;
   logic [AW-1:0]       wa_addr, wi_addr, claim_addr;
   logic [DW-1:0]       wa_data, wi_data;
   logic                ready_a, ready_b, conf_a, conf_b;

   int errors = 0;
   int checks = 0;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(0)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pending(rd_pend_a),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wi_en(wi_en), .wi_addr(wi_addr), .wi_data(wi_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .ready(ready_a), .wr_conflict(conf_a));

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pend_b),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wi_en(wi_en), .wi_addr(wi_addr), .wi_data(wi_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .ready(ready_b), .wr_conflict(conf_b));

   // Reference model: index 0 = dut_a, index 1 = dut_b.
   logic [DW-1:0] m_reg  [2][DEPTH];
   bit            m_pend [2][DEPTH];
   bit            m_zero [2] = '{1'b0, 1'b1};
   bit            m_byp  [2] = '{1'b1, 1'b0};
   int            m_init;
   bit            m_conf;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input int i, input logic [AW-1:0] a);
      if (m_init < DEPTH)                        return '0;
      if (m_zero[i] && a == '0)                  return '0;
      if (m_byp[i] && wi_en && wi_addr == a)     return wi_data;
      if (m_byp[i] && wa_en && wa_addr == a)     return wa_data;
      return m_reg[i][a];
   endfunction

   function automatic bit m_pend_rd(input int i, input logic [AW-1:0] a);
      if (m_init < DEPTH) return 1'b0;
      return m_pend[i][a];
   endfunction

   task automatic model_reset();
      m_init = 0;
      m_conf = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < DEPTH; r++) m_pend[i][r] = 1'b0;
   endtask

   task automatic model_edge();
      if (m_init < DEPTH) begin
         for (int i = 0; i < 2; i++) m_reg[i][m_init] = '0;
         m_init++;
         m_conf = 1'b0;
      end else begin
         m_conf = wa_en && wi_en && (wa_addr == wi_addr);
         for (int i = 0; i < 2; i++) begin
            // ALU first, ID second: ID data survives a collision.
            if (wa_en && !(m_zero[i] && wa_addr == '0)) begin
               m_reg[i][wa_addr]  = wa_data;
               m_pend[i][wa_addr] = 1'b0;
            end
            if (wi_en && !(m_zero[i] && wi_addr == '0)) begin
               m_reg[i][wi_addr]  = wi_data;
               m_pend[i][wi_addr] = 1'b0;
            end
            if (claim_en && !(m_zero[i] && claim_addr == '0))
               m_pend[i][claim_addr] = 1'b1;
         end
      end
   endtask

   task automatic idle();
      wa_en = 1'b0; wi_en = 1'b0; claim_en = 1'b0;
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic cycle();
      logic [AW-1:0] a;
      #1;
      for (int k = 0; k < NR; k++) begin
         a = rd_addr[k*AW +: AW];
         chk("rd_data_a", rd_data_a[k*DW +: DW], m_read(0, a));
         chk("rd_data_b", rd_data_b[k*DW +: DW], m_read(1, a));
         chk("rd_pend_a", DW'(rd_pend_a[k]), DW'(m_pend_rd(0, a)));
         chk("rd_pend_b", DW'(rd_pend_b[k]), DW'(m_pend_rd(1, a)));
      end
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      chk("ready_a", DW'(ready_a), DW'(m_init >= DEPTH));
      chk("ready_b", DW'(ready_b), DW'(m_init >= DEPTH));
      chk("conf_a",  DW'(conf_a),  DW'(m_conf));
      chk("conf_b",  DW'(conf_b),  DW'(m_conf));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      idle();
      @(posedge clk);
      @(negedge clk);
      chk("reset_ready", DW'(ready_a), '0);
      chk("reset_conf",  DW'(conf_a),  '0);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      wa_addr = '0; wi_addr = '0; claim_addr = '0;
      wa_data = '0; wi_data = '0;
      idle();
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < DEPTH; r++) m_reg[i][r] = '0;
      @(negedge clk);
      do_reset();

      // Clear sequence: ready low for 8 cycles, reads 0 meanwhile.
      for (int c = 1; c <= 8; c++) begin
         rd_addr = (NR*AW)'($urandom);
         #1 chk("init_rd0", rd_data_a[0 +: DW], '0);
         cycle();
         chk("ready_rise", DW'(ready_a), DW'(c == 8));
      end
      for (int r = 0; r < DEPTH; r++) begin
         rd_addr = {AW'(r), AW'(r)};
         #1 chk("post_clear", rd_data_a[DW +: DW], '0);
         cycle();
      end

      // Reset during INIT restarts the clear; early write ignored.
      do_reset();
      for (int c = 0; c < 3; c++) cycle();
      do_reset();
      wa_en = 1'b1; wa_addr = 3'd3; wa_data = 32'hDEADBEEF;
      for (int c = 1; c <= 8; c++) begin
         cycle();
         if (c == 1) idle();
         chk("ready_rise2", DW'(ready_a), DW'(c == 8));
      end
      rd_addr = {3'd0, 3'd3};
      #1 chk("r3_ignored", rd_data_a[0 +: DW], '0);
      cycle();

      // Two ports to different addresses, bypass on port 0.
      rd_addr = {3'd0, 3'd2};
      wa_en = 1'b1; wa_addr = 3'd2; wa_data = 32'h11111111;
      wi_en = 1'b1; wi_addr = 3'd5; wi_data = 32'h22222222;
      #1 chk("bypass_a", rd_data_a[0 +: DW], 32'h11111111);
      chk("nobypass_b", rd_data_b[0 +: DW], '0);
      cycle();
      chk("no_conflict", DW'(conf_a), '0);
      idle();
      rd_addr = {3'd0, 3'd5};
      #1 chk("r5_value", rd_data_a[0 +: DW], 32'h22222222);
      cycle();

      // Same-address collision: ID wins, conflict pulses once.
      wa_en = 1'b1; wa_addr = 3'd4; wa_data = 32'hAAAA0000;
      wi_en = 1'b1; wi_addr = 3'd4; wi_data = 32'h0000BBBB;
      cycle();
      chk("conflict_hi", DW'(conf_a), 32'd1);
      idle();
      rd_addr = {3'd0, 3'd4};
      #1 chk("r4_id_wins_a", rd_data_a[0 +: DW], 32'h0000BBBB);
      chk("r4_id_wins_b", rd_data_b[0 +: DW], 32'h0000BBBB);
      cycle();
      chk("conflict_lo", DW'(conf_a), '0);

      // Scoreboard: claim, claim beats write, write resolves.
      claim_en = 1'b1; claim_addr = 3'd6;
      cycle();
      idle();
      rd_addr = {3'd6, 3'd0};
      #1 chk("pend_set", DW'(rd_pend_a[1]), 32'd1);
      cycle();
      wa_en = 1'b1; wa_addr = 3'd6; wa_data = 32'h5;
      claim_en = 1'b1; claim_addr = 3'd6;
      cycle();
      idle();
      #1 chk("pend_claim_wins", DW'(rd_pend_a[1]), 32'd1);
      cycle();
      wa_en = 1'b1; wa_addr = 3'd6; wa_data = 32'h7;
      cycle();
      idle();
      #1 chk("pend_cleared", DW'(rd_pend_a[1]), '0);
      chk("r6_value", rd_data_a[DW +: DW], 32'h7);
      cycle();

      // Zero register and no-bypass build.
      wa_en = 1'b1; wa_addr = 3'd0; wa_data = 32'hFFFFFFFF;
      claim_en = 1'b1; claim_addr = 3'd0;
      cycle();
      idle();
      rd_addr = {3'd0, 3'd0};
      #1 chk("zero_data_b", rd_data_b[0 +: DW], '0);
      chk("zero_pend_b", DW'(rd_pend_b[0]), '0);
      chk("r0_data_a", rd_data_a[0 +: DW], 32'hFFFFFFFF);
      chk("r0_pend_a", DW'(rd_pend_a[0]), 32'd1);
      cycle();
      rd_addr = {3'd0, 3'd1};
      wa_en = 1'b1; wa_addr = 3'd1; wa_data = 32'h9;
      #1 chk("old_val_b", rd_data_b[0 +: DW], '0);
      chk("byp_val_a", rd_data_a[0 +: DW], 32'h9);
      cycle();
      idle();
      #1 chk("new_val_b", rd_data_b[0 +: DW], 32'h9);
      cycle();

      // Randomized traffic, including a reset in the middle.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         rd_addr    = (NR*AW)'($urandom);
         wa_en      = 1'($urandom);
         wa_addr    = AW'($urandom);
         wa_data    = $urandom;
         wi_en      = 1'($urandom);
         wi_addr    = AW'($urandom);
         wi_data    = $urandom;
         claim_en   = 1'($urandom);
         claim_addr = AW'($urandom);
         cycle();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 8x32 two-read/one-write register file.
- Width, depth and read-port count are parameters. The ALU and ID sources become two independent write ports instead of a muxed single port.
- Adds a post-reset sequential clear FSM, optional write-to-read bypass, optional hardwired zero register, and a per-register pending scoreboard so ID can stall on unresolved producers.
- Sits between ID (reads, claims, immediate writes) and ALU writeback.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of asynchronous read ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, packed; port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_pending  out  NUM_RD  pending bit of each addressed register.
- wa_en  in  1  ALU write enable.
- wa_addr  in  ADDR_W  ALU write address.
- wa_data  in  DATA_W  ALU write data.
- wi_en  in  1  ID write enable.
- wi_addr  in  ADDR_W  ID write address.
- wi_data  in  DATA_W  ID write data.
- claim_en  in  1  mark a register as awaiting a producer.
- claim_addr  in  ADDR_W  register to claim.
- ready  out  1  high once the initial clear has finished.
- wr_conflict  out  1  registered one-cycle pulse: both write ports targeted the same address.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to INIT and clear counter goes to 0.
  - Pending bits are all 0, ready=0, wr_conflict=0.
  - The storage array has no reset, so it can be RAM-inferred.
- FSM states: INIT and RUN.
  - INIT: each cycle write 0 to register[cnt], then cnt++. After writing DEPTH-1, go to RUN, so ready rises DEPTH cycles after rst deasserts (8 with defaults).
  - RUN: terminal state; only rst leaves it.
  - Asserting rst mid-INIT restarts the clear from index 0.
- During INIT:
  - wa_en, wi_en and claim_en are ignored.
  - rd_data reads 0 and rd_pending reads 0.
- Reads are combinational. rd_data[k] = register[rd_addr[k]], with these overrides:
  - ZERO_REG=1 and address 0: returns 0.
  - BYPASS=1 and an enabled write targets the same address this cycle: returns that write's data, using the same ID-over-ALU priority as the write itself.
  - BYPASS=0: the old value is returned until the next edge.
- Writes (RUN only) commit on the clock edge.
  - The two ports to different addresses both commit.
  - The two ports to the same address: ID data is stored, and wr_conflict=1 for the following cycle.
- Scoreboard, pending[DEPTH] (RUN only):
  - Any committed write to register r clears pending[r] at the edge.
  - claim_en sets pending[claim_addr] at the edge.
  - Claim and write to the same register in the same cycle: the claim wins and pending stays 1 (a new producer).
  - Claiming a register that is already pending leaves it at 1.
  - With ZERO_REG=1, claims and writes to register 0 are no-ops.
  - rd_pending[k] = pending[rd_addr[k]]. Not bypassed: it reflects the registered value.
- Address width is exact, so there are no out-of-range addresses.

Decomposition:
- Shared package (rf_pkg): DATA_W/ADDR_W defaults, the FSM state typedef {INIT, RUN}, and packed-slice helper functions.
- One sub-module, rf_scoreboard: the pending bit vector with claim/clear priority and the ZERO_REG mask. It is instantiated once.
- Storage, INIT FSM and the read muxes stay in the top level.

Test Plan:
1. Pulse rst and hold all enables low; count cycles. -> ready=0 for exactly 8 cycles, then 1. All rd_data=0. Reading any register after ready returns 0x00000000.
2. Assert rst in INIT cycle 4; release, write wa r3=0xDEADBEEF right after release. -> The write is ignored, ready rises 8 cycles after the second release, and r3 reads 0.
3. In RUN, in one cycle: wa r2=0x11111111, wi r5=0x22222222, rd_addr0=2, BYPASS=1. -> rd_data0=0x11111111 in that same cycle. Next cycle r5 reads 0x22222222 and wr_conflict=0.
4. wa r4=0xAAAA0000 and wi r4=0x0000BBBB in the same cycle. -> r4 reads 0x0000BBBB and wr_conflict pulses 1 for exactly one cycle.
5. claim r6; next cycle rd_addr1=6. -> rd_pending1=1. Then wa r6=0x5 together with claim r6 -> pending stays 1. Then wa r6=0x7 alone -> pending 0 and r6 reads 0x7.
6. ZERO_REG=1: wa r0=0xFFFFFFFF and claim r0 in the same cycle. -> r0 reads 0 and rd_pending=0. With BYPASS=0, a same-cycle write r1=0x9 while reading r1 returns the old value 0, and 0x9 the next cycle.
